// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment display blocks: segment patterns
// (active-low, {g,f,e,d,c,b,a}), per-slot anode masks and the scan slot type.
package sevenseg_pkg;

  localparam int SLOT_W = 2;

  typedef enum logic [SLOT_W-1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_PAD2 = 2'd2,
    SLOT_PAD3 = 2'd3
  } slot_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_NONE = 4'b1111;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup, shared by any display block that needs a digit glyph.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Four-slot multiplexed display scanner for the two-digit BCD counter.
// Inputs are snapshotted once per frame so a counter update never tears
// the display; all outputs are registered and switch together.
//
// state     | meaning
// SLOT_ONES | ones digit on AN[0]
// SLOT_TENS | tens digit on AN[1], carry on DP, optional leading-zero blank
// SLOT_PAD2 | all anodes off (keeps scan rate uniform)
// SLOT_PAD3 | all anodes off; tick here wraps the frame and loads snapshots
module bcd_sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] Q1,
  input  logic [3:0] Q2,
  input  logic       CO,
  input  logic       LZB,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [3:0] AN,
  output logic       FRAME
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0] pre, pre_nxt;
  slot_t            slot, slot_nxt;
  logic [3:0]       s_q1, s_q2, s_q1_nxt, s_q2_nxt;
  logic             s_co, s_lzb, s_co_nxt, s_lzb_nxt;
  logic             slot_tick, wrap;
  logic [6:0]       seg_ones, seg_tens;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;
  logic             dp_nxt;
  logic             tens_blank;

  // Output registers are loaded from next-state decode so SEG/AN/DP line up
  // with the slot they belong to, with no extra cycle of latency.
  bcd_to_seg u_dec_ones (.bcd(s_q1_nxt), .seg(seg_ones));
  bcd_to_seg u_dec_tens (.bcd(s_q2_nxt), .seg(seg_tens));

  // Prescaler, slot sequencing and frame-wrap snapshot selection.
  always_comb begin
    slot_tick = (pre == PRE_LAST);
    pre_nxt   = slot_tick ? '0 : pre + 1'b1;
    slot_nxt  = slot;
    if (slot_tick) begin
      case (slot)
        SLOT_ONES: slot_nxt = SLOT_TENS;
        SLOT_TENS: slot_nxt = SLOT_PAD2;
        SLOT_PAD2: slot_nxt = SLOT_PAD3;
        SLOT_PAD3: slot_nxt = SLOT_ONES;
        default:   slot_nxt = SLOT_ONES;
      endcase
    end
    wrap      = slot_tick && (slot == SLOT_PAD3);
    s_q1_nxt  = wrap ? Q1  : s_q1;
    s_q2_nxt  = wrap ? Q2  : s_q2;
    s_co_nxt  = wrap ? CO  : s_co;
    s_lzb_nxt = wrap ? LZB : s_lzb;
  end

  // Anode, segment and decimal-point selection for the upcoming slot.
  always_comb begin
    tens_blank = s_lzb_nxt && (s_q2_nxt == 4'd0);
    an_nxt     = AN_NONE;
    seg_nxt    = SEG_BLANK;
    dp_nxt     = 1'b1;
    case (slot_nxt)
      SLOT_ONES: begin
        an_nxt  = AN_ONES;
        seg_nxt = seg_ones;
      end
      SLOT_TENS: begin
        seg_nxt = seg_tens;
        an_nxt  = tens_blank ? AN_NONE : AN_TENS;
        dp_nxt  = tens_blank ? 1'b1 : ~s_co_nxt;
      end
      default: begin
        an_nxt  = AN_NONE;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset wins over a coincident slot tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre   <= '0;
      slot  <= SLOT_ONES;
      s_q1  <= 4'd0;
      s_q2  <= 4'd0;
      s_co  <= 1'b0;
      s_lzb <= 1'b0;
      AN    <= AN_ONES;
      SEG   <= SEG_0;
      DP    <= 1'b1;
      FRAME <= 1'b1;
    end else begin
      pre   <= pre_nxt;
      slot  <= slot_nxt;
      s_q1  <= s_q1_nxt;
      s_q2  <= s_q2_nxt;
      s_co  <= s_co_nxt;
      s_lzb <= s_lzb_nxt;
      AN    <= an_nxt;
      SEG   <= seg_nxt;
      DP    <= dp_nxt;
      FRAME <= wrap;
    end
  end

endmodule
